// File: rtl/stream_framer_pkg.sv
// Shared types and header layout for the stream framer and its buffer.
package framer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Header occupies the top HDR_W bits of the beat, fields MSB first.
  localparam int HDR_FIELD_W   = 16;
  localparam int HDR_FIELDS    = 4;
  localparam int HDR_W         = HDR_FIELD_W * HDR_FIELDS;
  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_SEQ_LSB   = 32;
  localparam int HDR_RECS_LSB  = 16;
  localparam int HDR_BEATS_LSB = 0;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hE7E1;

  function automatic logic [HDR_W-1:0] pack_header(
    input logic [HDR_FIELD_W-1:0] magic,
    input logic [HDR_FIELD_W-1:0] seq,
    input logic [HDR_FIELD_W-1:0] recs,
    input logic [HDR_FIELD_W-1:0] beats
  );
    logic [HDR_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: HDR_FIELD_W] = magic;
    hdr[HDR_SEQ_LSB   +: HDR_FIELD_W] = seq;
    hdr[HDR_RECS_LSB  +: HDR_FIELD_W] = recs;
    hdr[HDR_BEATS_LSB +: HDR_FIELD_W] = beats;
    return hdr;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; data needs no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_framer.sv
// Packs tagged record beats into header-prefixed frames, flushing on a
// record-count threshold or after an idle timeout.
module stream_framer
  import framer_pkg::*;
#(
  parameter int          DATA_WIDTH     = 128,
  parameter int          ID_WIDTH       = 32,
  parameter int          DEST_WIDTH     = 32,
  parameter int          USER_WIDTH     = 64,
  parameter int          FIFO_DEPTH     = 64,
  parameter int          MAX_RECORDS    = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] MAGIC          = DEFAULT_MAGIC
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   stream_tdata,
  input  logic [DATA_WIDTH/8-1:0] stream_tstrb,
  input  logic                    stream_tlast,
  input  logic                    stream_tvalid,
  output logic                    stream_tready,
  output logic [DATA_WIDTH-1:0]   frame_tdata,
  output logic [DATA_WIDTH/8-1:0] frame_tstrb,
  output logic [DATA_WIDTH/8-1:0] frame_tkeep,
  output logic                    frame_tlast,
  output logic                    frame_tvalid,
  input  logic                    frame_tready,
  output logic [ID_WIDTH-1:0]     frame_tid,
  output logic [DEST_WIDTH-1:0]   frame_tdest,
  output logic [USER_WIDTH-1:0]   frame_tuser,
  output logic [15:0]             frame_seq
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int FW     = DATA_WIDTH + STRB_W;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES);

  state_t            state;
  state_t            next_state;
  logic              ready_en;
  logic [CW-1:0]     recs_done;
  logic [CW-1:0]     beats_done;
  logic [CW-1:0]     beats_partial;
  logic [CW-1:0]     f_recs;
  logic [CW-1:0]     f_beats;
  logic [CW-1:0]     pay_cnt;
  logic [TW-1:0]     timer;
  logic [15:0]       seq;

  logic              accept;
  logic              trig;
  logic              start;
  logic              last_beat;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_count_unused;
  logic [FW-1:0]     fifo_head;
  logic [HDR_W-1:0]  hdr_word;
  logic [CW-1:0]     recs_next;
  logic [CW-1:0]     beats_next;
  logic [CW-1:0]     partial_next;

  assign frame_tkeep       = '1;
  assign frame_tid         = '0;
  assign frame_tdest       = '0;
  assign frame_tuser       = '0;
  assign frame_seq         = seq;
  // Occupancy is available for debug probing; nothing here needs it.
  assign fifo_count_unused = ^fifo_count;

  assign stream_tready = ready_en && !fifo_full;
  assign accept        = stream_tvalid && stream_tready;
  assign trig          = (recs_done >= CW'(MAX_RECORDS)) ||
                         ((recs_done != '0) && (timer == TW'(TIMEOUT_CYCLES - 1)));
  assign start         = (state == IDLE) && trig;
  assign last_beat     = (state == PAYLOAD) && (pay_cnt == f_beats - CW'(1));
  assign fifo_pop      = (state == PAYLOAD) && frame_tready && !fifo_empty;
  assign hdr_word      = pack_header(MAGIC, seq, 16'(f_recs), 16'(f_beats));

  stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (accept),
    .push_data ({stream_tdata, stream_tstrb}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next values of the pending-record counters: a frame start removes the
  // snapshot first, then a same-cycle record end is credited to the next frame.
  always_comb begin
    recs_next    = recs_done;
    beats_next   = beats_done;
    partial_next = beats_partial;
    if (start) begin
      recs_next  = '0;
      beats_next = '0;
    end else begin
      recs_next  = recs_done;
      beats_next = beats_done;
    end
    if (accept) begin
      if (stream_tlast) begin
        recs_next    = recs_next + CW'(1);
        beats_next   = beats_next + beats_partial + CW'(1);
        partial_next = '0;
      end else begin
        partial_next = beats_partial + CW'(1);
      end
    end else begin
      partial_next = beats_partial;
    end
  end

  // Pending-record counters, frame snapshots and the payload beat counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      recs_done     <= '0;
      beats_done    <= '0;
      beats_partial <= '0;
      f_recs        <= '0;
      f_beats       <= '0;
      pay_cnt       <= '0;
    end else begin
      recs_done     <= recs_next;
      beats_done    <= beats_next;
      beats_partial <= partial_next;
      if (start) begin
        f_recs  <= recs_done;
        f_beats <= beats_done;
        pay_cnt <= '0;
      end else if (fifo_pop) begin
        pay_cnt <= pay_cnt + CW'(1);
      end
    end
  end

  // Idle timer: runs only while records wait in IDLE, cleared by a frame start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if ((state == IDLE) && (recs_done != '0) && !start) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end

  // Input enable and frame sequence number.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      seq      <= 16'd0;
    end else begin
      ready_en <= 1'b1;
      if ((state == HEADER) && frame_tready) begin
        seq <= seq + 16'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (trig) next_state = HEADER;
        else      next_state = IDLE;
      end
      HEADER: begin
        if (frame_tready) next_state = PAYLOAD;
        else              next_state = HEADER;
      end
      PAYLOAD: begin
        if (frame_tready && last_beat) next_state = IDLE;
        else                           next_state = PAYLOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output beat selection; everything is driven from registered state.
  always_comb begin
    frame_tvalid = 1'b0;
    frame_tlast  = 1'b0;
    frame_tdata  = '0;
    frame_tstrb  = '0;
    case (state)
      IDLE: begin
        frame_tvalid = 1'b0;
      end
      HEADER: begin
        frame_tvalid = 1'b1;
        frame_tdata  = DATA_WIDTH'(hdr_word) << (DATA_WIDTH - HDR_W);
        frame_tstrb  = '1;
      end
      PAYLOAD: begin
        frame_tvalid = 1'b1;
        frame_tdata  = fifo_head[FW-1:STRB_W];
        frame_tstrb  = fifo_head[STRB_W-1:0];
        frame_tlast  = last_beat;
      end
      default: begin
        frame_tvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_framer.sv
// Randomised bench for stream_framer against a queue-based frame model.
module tb_stream_framer;

  localparam int DW    = 128;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 8;
  localparam int MAXR  = 2;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] stream_tdata = '0;
  logic [SW-1:0] stream_tstrb = '0;
  logic          stream_tlast = 1'b0;
  logic          stream_tvalid = 1'b0;
  logic          stream_tready;
  logic [DW-1:0] frame_tdata;
  logic [SW-1:0] frame_tstrb;
  logic [SW-1:0] frame_tkeep;
  logic          frame_tlast;
  logic          frame_tvalid;
  logic          frame_tready = 1'b0;
  logic [31:0]   frame_tid;
  logic [31:0]   frame_tdest;
  logic [63:0]   frame_tuser;
  logic [15:0]   frame_seq;

  always #5 clk = ~clk;

  stream_framer #(
    .DATA_WIDTH(DW), .ID_WIDTH(32), .DEST_WIDTH(32), .USER_WIDTH(64),
    .FIFO_DEPTH(DEPTH), .MAX_RECORDS(MAXR), .TIMEOUT_CYCLES(TMO), .MAGIC(16'hE7E1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .stream_tdata(stream_tdata), .stream_tstrb(stream_tstrb), .stream_tlast(stream_tlast),
    .stream_tvalid(stream_tvalid), .stream_tready(stream_tready),
    .frame_tdata(frame_tdata), .frame_tstrb(frame_tstrb), .frame_tkeep(frame_tkeep),
    .frame_tlast(frame_tlast), .frame_tvalid(frame_tvalid), .frame_tready(frame_tready),
    .frame_tid(frame_tid), .frame_tdest(frame_tdest), .frame_tuser(frame_tuser),
    .frame_seq(frame_seq)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic          payload;
  } beat_t;

  // Model: beats still to send, accepted beats not yet framed, expected output.
  beat_t       src_q[$];
  beat_t       pend_q[$];
  beat_t       out_q[$];
  int          pend_recs, pend_beats, partial, wait_cnt, occ;
  bit          ready_en;
  logic [15:0] m_seq;
  int          vprob, rprob, stall_cnt;
  int          cyc, last_acc_cyc;
  int          total, bad;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    src_q.delete(); pend_q.delete(); out_q.delete();
    pend_recs = 0; pend_beats = 0; partial = 0; wait_cnt = 0; occ = 0;
    ready_en = 1'b0; m_seq = 16'd0;
    stream_tvalid = 1'b0; stream_tdata = '0; stream_tstrb = '0; stream_tlast = 1'b0;
  endtask

  function automatic beat_t header_beat(logic [15:0] seq, int recs, int beats);
    beat_t h;
    h.data    = {16'hE7E1, seq, 16'(recs), 16'(beats), 64'h0};
    h.strb    = '1;
    h.last    = 1'b0;
    h.payload = 1'b0;
    return h;
  endfunction

  task automatic add_record(input int len, input logic [DW-1:0] first_data, input bit fixed);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data    = {$urandom, $urandom, $urandom, $urandom};
      if (fixed && i == 0) b.data = first_data;
      b.strb    = 16'($urandom);
      b.last    = (i == len - 1);
      b.payload = 1'b0;
      src_q.push_back(b);
    end
  endtask

  task automatic drive(input bit acc);
    if (stream_tvalid && !acc) begin
      stream_tvalid = 1'b1;
    end else if (src_q.size() > 0 && $urandom_range(99) < vprob) begin
      stream_tvalid = 1'b1;
      stream_tdata  = src_q[0].data;
      stream_tstrb  = src_q[0].strb;
      stream_tlast  = src_q[0].last;
    end else begin
      stream_tvalid = 1'b0; stream_tdata = '0; stream_tstrb = '0; stream_tlast = 1'b0;
    end
    if (stall_cnt > 0) begin
      frame_tready = 1'b0;
      stall_cnt--;
    end else begin
      frame_tready = ($urandom_range(99) < rprob);
    end
  endtask

  // One clock: compare outputs with the model, advance the model over the edge, drive.
  task automatic step();
    bit    acc, hs, trig, m_ready;
    beat_t b;
    m_ready = ready_en && (occ < DEPTH);
    check("stream_tready", DW'(stream_tready), DW'(m_ready));
    check("frame_tvalid", DW'(frame_tvalid), DW'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      check("frame_tdata", frame_tdata, out_q[0].data);
      check("frame_tstrb", DW'(frame_tstrb), DW'(out_q[0].strb));
      check("frame_tlast", DW'(frame_tlast), DW'(out_q[0].last));
    end
    check("frame_seq", DW'(frame_seq), DW'(m_seq));
    acc = stream_tvalid && m_ready;
    hs  = (out_q.size() != 0) && frame_tready;
    @(posedge clk);
    cyc++;
    trig = (out_q.size() == 0) &&
           (pend_recs >= MAXR || (pend_recs > 0 && wait_cnt == TMO - 1));
    if (out_q.size() == 0 && pend_recs > 0 && !trig) wait_cnt++;
    else wait_cnt = 0;
    if (hs) begin
      b = out_q.pop_front();
      if (b.payload) occ--;
      else m_seq = m_seq + 16'd1;
    end
    if (trig) begin
      out_q.push_back(header_beat(m_seq, pend_recs, pend_beats));
      for (int i = 0; i < pend_beats; i++) begin
        b = pend_q.pop_front();
        b.last = (i == pend_beats - 1);
        b.payload = 1'b1;
        out_q.push_back(b);
      end
      pend_recs = 0; pend_beats = 0;
    end
    if (acc) begin
      b = src_q.pop_front();
      pend_q.push_back(b);
      occ++; partial++;
      if (b.last) begin
        pend_recs++; pend_beats += partial; partial = 0;
        last_acc_cyc = cyc;
      end
    end
    ready_en = 1'b1;
    #1;
    drive(acc);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || pend_recs > 0 || out_q.size() > 0) && n < budget) begin
      step(); n++;
    end
    check("drain_done", DW'(n < budget), DW'(1'b1));
  endtask

  task automatic wait_payload(input int budget);
    int n;
    n = 0;
    while (!(out_q.size() > 0 && out_q[0].payload) && n < budget) begin
      step(); n++;
    end
    check("reach_payload", DW'(n < budget), DW'(1'b1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hdr_cyc, n;
    bit saw_full;
    total = 0; bad = 0; cyc = 0; last_acc_cyc = 0; stall_cnt = 0;
    vprob = 100; rprob = 100;
    model_reset();

    // Reset state
    #1;
    check("rst_tvalid", DW'(frame_tvalid), DW'(1'b0));
    check("rst_tlast", DW'(frame_tlast), DW'(1'b0));
    check("rst_tdata", frame_tdata, '0);
    check("rst_tstrb", DW'(frame_tstrb), '0);
    check("rst_tready", DW'(stream_tready), DW'(1'b0));
    check("rst_seq", DW'(frame_seq), '0);
    check("tkeep", DW'(frame_tkeep), DW'({SW{1'b1}}));
    check("tid_tdest_tuser", DW'({frame_tid, frame_tdest, frame_tuser}), '0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    frame_tready = 1'b1;

    // 1-beat AR record then 2-beat R record: threshold frame of 2 records, 3 beats
    add_record(1, 128'h1000, 1'b1);
    add_record(2, '0, 1'b0);
    drain(200);
    check("seq_after_first", DW'(frame_seq), DW'(16'd1));

    // Lone record flushed by the timeout
    add_record(1, '0, 1'b0);
    hdr_cyc = -1;
    n = 0;
    while ((src_q.size() > 0 || pend_recs > 0 || out_q.size() > 0) && n < 200) begin
      if (frame_tvalid && hdr_cyc < 0) hdr_cyc = cyc;
      step(); n++;
    end
    check("timeout_latency", DW'(hdr_cyc - last_acc_cyc), DW'(TMO));

    // Three back-to-back records: the third ends on the trigger edge
    add_record(1, '0, 1'b0);
    add_record(1, '0, 1'b0);
    add_record(1, '0, 1'b0);
    drain(300);

    // Downstream stall during payload while input keeps arriving
    for (int i = 0; i < 12; i++) add_record($urandom_range(1, 2), '0, 1'b0);
    wait_payload(200);
    frame_tready = 1'b0;
    stall_cnt = 19;
    saw_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!stream_tready) saw_full = 1'b1;
      step();
    end
    check("stall_fills_fifo", DW'(saw_full), DW'(1'b1));
    drain(1000);

    // Sequence number wrap
    force dut.seq = 16'hFFFF;
    #1;
    release dut.seq;
    m_seq = 16'hFFFF;
    add_record(1, '0, 1'b0);
    add_record(2, '0, 1'b0);
    drain(300);
    check("seq_wrapped", DW'(frame_seq), DW'(16'd0));
    add_record(2, '0, 1'b0);
    add_record(1, '0, 1'b0);
    drain(300);

    // Random traffic with random backpressure
    vprob = 60; rprob = 70;
    for (int i = 0; i < 150; i++) add_record($urandom_range(1, 2), '0, 1'b0);
    drain(5000);

    // Asynchronous reset in the middle of a payload
    vprob = 100; rprob = 100;
    for (int i = 0; i < 4; i++) add_record(2, '0, 1'b0);
    wait_payload(200);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_tvalid", DW'(frame_tvalid), DW'(1'b0));
    check("midrst_tdata", frame_tdata, '0);
    check("midrst_tready", DW'(stream_tready), DW'(1'b0));
    check("midrst_seq", DW'(frame_seq), '0);
    model_reset();
    frame_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3 * TMO; i++) step();
    add_record(1, '0, 1'b0);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
